zipdbg_bridge: RTL
==================

Name: zipdbg_bridge

Overview:
- Host-side sequencer that drives the two-register Zip CPU debug wishbone slave port (addr 0 = control, addr 1 = data).
- Turns single host commands (read CPU reg, write CPU reg, read control, write control) into the required control-write + data-access sequence.
- Returns one response per command.
- Sits between the host command decoder (UART/hex bus) and the CPU's debug slave interface.

Parameters:
- TIMEOUT_LG, 10: width of the ack-timeout counter; timeout fires after 2^TIMEOUT_LG-1 cycles of waiting for an ack.
- HALT_ON_ACCESS, 1: when 1, register-access control writes set bit 10 (halt); when 0, bit 10 is 0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_stb  in  1  command valid; accepted when o_cmd_busy=0
- i_cmd_op  in  2  00 read CPU reg, 01 write CPU reg, 10 read control, 11 write control
- i_cmd_reg  in  5  CPU register index (ops 00/01)
- i_cmd_data  in  32  write data (ops 01/11)
- o_cmd_busy  out  1  command in progress
- o_rsp_stb  out  1  one-cycle response pulse
- o_rsp_data  out  32  read data (0 for write ops and on error)
- o_rsp_err  out  1  response is a timeout error
- o_dbg_cyc  out  1  wishbone cycle
- o_dbg_stb  out  1  wishbone strobe
- o_dbg_we  out  1  wishbone write enable
- o_dbg_addr  out  1  0 = control reg, 1 = data reg
- o_dbg_data  out  32  wishbone write data
- i_dbg_ack  in  1  wishbone ack
- i_dbg_stall  in  1  wishbone stall
- i_dbg_data  in  32  wishbone read data

Behaviour:
- Reset is i_rst, synchronous, active-high, on clock i_clk.
- Reset values: o_cmd_busy=0, o_rsp_stb=0, o_rsp_err=0, o_rsp_data=0, o_dbg_cyc=0, o_dbg_stb=0, o_dbg_we=0, o_dbg_addr=0, o_dbg_data=0; state IDLE.
- i_rst mid-operation: abort immediately; cyc/stb drop on the next edge; no response is issued.
- States: IDLE, CTL_REQ, CTL_WAIT, DAT_REQ, DAT_WAIT, RESP.
- IDLE: on i_cmd_stb, latch op/reg/data and set busy.
  - ops 00/01 -> CTL_REQ, with o_dbg_data = {21'h0, HALT_ON_ACCESS, 5'h0, reg}, we=1, addr=0.
  - op 10 -> DAT_REQ, with addr=0, we=0.
  - op 11 -> DAT_REQ, with addr=0, we=1, o_dbg_data = i_cmd_data.
- CTL_REQ: cyc=stb=1. If !i_dbg_stall, stb drops next cycle -> CTL_WAIT.
- CTL_WAIT: cyc=1, stb=0. On i_dbg_ack, go to DAT_REQ with addr=1 and we per op; o_dbg_data = i_cmd_data for op 01. cyc stays high across both phases.
- DAT_REQ / DAT_WAIT: same handshake as CTL_REQ / CTL_WAIT.
  - On ack: capture i_dbg_data when we=0, drop cyc -> RESP.
- RESP: o_rsp_stb=1 for exactly one cycle, then IDLE.
- o_cmd_busy is high from the cycle after acceptance through the RESP cycle inclusive.
- Commands presented while busy are ignored (no queue).
- An ack arriving in the same cycle as stb is accepted (CTL_REQ/DAT_REQ treat ack as done when !stall).
- Stall held indefinitely: stb stays high, unless the timeout is enabled.
- Latency, zero-stall slave acking one cycle after stb:
  - CPU reg op: stb at cycles 1 and 3, o_rsp_stb at cycle 5 after acceptance edge 0.
  - Control op: o_rsp_stb at cycle 3.
- o_rsp_data holds its value until the next response; it is zero for write ops.

Optional Feature:
- Macro ZIPDBG_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_LG-bit counter clears on entry to each *_REQ state and increments each cycle in *_REQ/*_WAIT.
  - On reaching all-ones: drop cyc/stb, go to RESP with o_rsp_err=1 and o_rsp_data=0.
  - A simultaneous ack on the terminal count wins (normal response).
- Undefined: no counter; waits forever; o_rsp_err is tied 0.

Test Plan:
- Op 00 reg 5, slave returns control ack then data 32'hDEADBEEF, no stall -> control write data 32'h00000405 at addr 0, then read at addr 1; o_rsp_data=32'hDEADBEEF, err=0, rsp at cycle 5.
- Op 01 reg 31, data 32'h12345678, slave stalls 3 cycles in each phase -> stb held 4 cycles per phase, write 32'h0000041F then 32'h12345678 at addr 1; one rsp, data 0.
- Op 11 data 32'h00000040 (reset) -> single write at addr 0, rsp at cycle 3; op 10 -> single read at addr 0, returns slave value.
- i_cmd_stb held high continuously for three commands -> exactly three responses; each subsequent command accepted the cycle after the preceding rsp.
- ZIPDBG_TIMEOUT_EN, TIMEOUT_LG=4, slave never acks -> cyc drops after 15 wait cycles; rsp_err=1, data 0; next command works normally.
- i_rst asserted during DAT_WAIT -> cyc/stb low next cycle; no rsp_stb; busy=0.

Source files
------------

// File: rtl/zipdbg_bridge.sv
// zipdbg_bridge: turns host debug commands into Zip CPU debug-port control/data
// wishbone sequences. Optional ack timeout enabled by defining ZIPDBG_TIMEOUT_EN.
module zipdbg_bridge #(
    parameter int TIMEOUT_LG     = 10,
    parameter bit HALT_ON_ACCESS = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_stb,
    input  logic [1:0]  i_cmd_op,
    input  logic [4:0]  i_cmd_reg,
    input  logic [31:0] i_cmd_data,
    output logic        o_cmd_busy,
    output logic        o_rsp_stb,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_dbg_cyc,
    output logic        o_dbg_stb,
    output logic        o_dbg_we,
    output logic        o_dbg_addr,
    output logic [31:0] o_dbg_data,
    input  logic        i_dbg_ack,
    input  logic        i_dbg_stall,
    input  logic [31:0] i_dbg_data
);
    typedef enum logic [2:0] {IDLE, CTL_REQ, CTL_WAIT, DAT_REQ, DAT_WAIT, RESP} state_t;

    state_t      state_q, state_n;
    logic [1:0]  op_q, op_n;
    logic [31:0] wdata_q, wdata_n;
    logic        busy_n, rsp_stb_n, cyc_n, stb_n, we_n, addr_n;
    logic [31:0] rsp_data_n, dbg_data_n;
    logic        in_req, phase_done, timed_out;

    if (TIMEOUT_LG < 2) begin : g_bad_timeout_lg
        $error("TIMEOUT_LG must be at least 2");
    end

    assign in_req     = (state_q == CTL_REQ) || (state_q == DAT_REQ);
    // An ack while the request is still stalled does not complete the phase.
    assign phase_done = i_dbg_ack && !(in_req && i_dbg_stall);

`ifdef ZIPDBG_TIMEOUT_EN
    localparam logic [TIMEOUT_LG-1:0] TMR_LAST = {{(TIMEOUT_LG-1){1'b1}}, 1'b0};

    logic [TIMEOUT_LG-1:0] timer_q;
    logic                  in_bus;

    assign in_bus    = (state_q != IDLE) && (state_q != RESP);
    // Fires on the edge at which the counter would reach all-ones.
    assign timed_out = in_bus && (timer_q == TMR_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            timer_q <= '0;
        else if ((state_n == CTL_REQ || state_n == DAT_REQ) && state_n != state_q)
            timer_q <= '0;
        else if (in_bus)
            timer_q <= timer_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_rsp_err <= 1'b0;
        else if (rsp_stb_n)
            o_rsp_err <= timed_out && !phase_done;
    end
`else
    assign timed_out = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-value starts at its held value so no path infers a latch.
        state_n    = state_q;
        op_n       = op_q;
        wdata_n    = wdata_q;
        busy_n     = o_cmd_busy;
        rsp_stb_n  = 1'b0;
        rsp_data_n = o_rsp_data;
        cyc_n      = o_dbg_cyc;
        stb_n      = o_dbg_stb;
        we_n       = o_dbg_we;
        addr_n     = o_dbg_addr;
        dbg_data_n = o_dbg_data;

        case (state_q)
            IDLE: if (i_cmd_stb) begin
                op_n    = i_cmd_op;
                wdata_n = i_cmd_data;
                busy_n  = 1'b1;
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
                addr_n  = 1'b0;
                if (!i_cmd_op[1]) begin
                    state_n    = CTL_REQ;
                    we_n       = 1'b1;
                    dbg_data_n = {21'h0, HALT_ON_ACCESS, 5'h0, i_cmd_reg};
                end else begin
                    state_n    = DAT_REQ;
                    we_n       = i_cmd_op[0];
                    dbg_data_n = i_cmd_data;
                end
            end
            CTL_REQ, CTL_WAIT, DAT_REQ, DAT_WAIT: begin
                if (phase_done) begin
                    if (state_q == CTL_REQ || state_q == CTL_WAIT) begin
                        state_n    = DAT_REQ;
                        stb_n      = 1'b1;
                        addr_n     = 1'b1;
                        we_n       = op_q[0];
                        dbg_data_n = wdata_q;
                    end else begin
                        state_n    = RESP;
                        cyc_n      = 1'b0;
                        stb_n      = 1'b0;
                        rsp_stb_n  = 1'b1;
                        rsp_data_n = o_dbg_we ? 32'h0 : i_dbg_data;
                    end
                end else if (timed_out) begin
                    state_n    = RESP;
                    cyc_n      = 1'b0;
                    stb_n      = 1'b0;
                    rsp_stb_n  = 1'b1;
                    rsp_data_n = 32'h0;
                end else if (in_req && !i_dbg_stall) begin
                    stb_n   = 1'b0;
                    state_n = (state_q == CTL_REQ) ? CTL_WAIT : DAT_WAIT;
                end
            end
            RESP: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            wdata_q    <= 32'h0;
            o_cmd_busy <= 1'b0;
            o_rsp_stb  <= 1'b0;
            o_rsp_data <= 32'h0;
            o_dbg_cyc  <= 1'b0;
            o_dbg_stb  <= 1'b0;
            o_dbg_we   <= 1'b0;
            o_dbg_addr <= 1'b0;
            o_dbg_data <= 32'h0;
        end else begin
            state_q    <= state_n;
            op_q       <= op_n;
            wdata_q    <= wdata_n;
            o_cmd_busy <= busy_n;
            o_rsp_stb  <= rsp_stb_n;
            o_rsp_data <= rsp_data_n;
            o_dbg_cyc  <= cyc_n;
            o_dbg_stb  <= stb_n;
            o_dbg_we   <= we_n;
            o_dbg_addr <= addr_n;
            o_dbg_data <= dbg_data_n;
        end
    end
endmodule
